// File: rtl/scan_mux_n.sv
// scan_mux_n: time-multiplexed display scanner with registered, aligned sel/bcd/an outputs.
// Define SCAN_LZ_BLANK_EN to also blank leading-zero channels above channel 0.
module scan_mux_n #(
  parameter int NCH = 6,
  parameter int W = 4,
  parameter int DIV = 50000,
  localparam int SW = $clog2(NCH) > 1 ? $clog2(NCH) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NCH*W-1:0] ch,
  input  logic en,
  input  logic [NCH-1:0] blank_mask,
  output logic [W-1:0] bcd,
  output logic [SW-1:0] sel,
  output logic [NCH-1:0] an,
  output logic frame
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  logic [PW-1:0] pcnt;
  logic [SW-1:0] idx;
  logic [NCH-1:0] blank;
  logic [W-1:0] data;
  logic blk, adv, wrap;
  assign adv = en && pcnt == PW'(DIV - 1);
  assign wrap = idx == SW'(NCH - 1);
`ifdef SCAN_LZ_BLANK_EN
  logic [NCH-1:0] lz;
  // lz[k]: channel k and every channel above it are zero; channel 0 is exempt
  always_comb begin
    lz[NCH-1] = ch[NCH*W-1 -: W] == '0;
    for (int k = NCH - 2; k >= 0; k--) lz[k] = lz[k+1] && ch[k*W +: W] == '0;
    blank = blank_mask | (lz & ~NCH'(1));
  end
`else
  assign blank = blank_mask;
`endif
  always_comb begin
    data = '0;
    blk = 1'b0;
    for (int k = 0; k < NCH; k++)
      if (idx == SW'(k)) begin
        data = ch[k*W +: W];
        blk = blank[k];
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pcnt <= '0;
      idx <= '0;
      sel <= '0;
      bcd <= '1;
      an <= '1;
      frame <= 1'b0;
    end else begin
      if (en) pcnt <= adv ? '0 : pcnt + 1'b1;
      if (adv) idx <= wrap ? '0 : idx + 1'b1;
      frame <= adv && wrap;
      sel <= idx;
      bcd <= blk ? '1 : data;
      an <= blk ? '1 : ~(NCH'(1) << idx);
    end
endmodule

// File: tb/tb_scan_mux_n.sv
// tb_scan_mux_n: table-driven check of scan order, blanking, freeze and reset on two configurations.
module tb_scan_mux_n;
`ifdef SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0, en = 1'b1;
  logic [23:0] ch = 24'h543210;
  logic [5:0] blank_mask = '0;
  logic [3:0] bcd;
  logic [2:0] sel;
  logic [5:0] an;
  logic frame;
  logic rst_nb = 1'b0, en_b = 1'b1;
  logic [11:0] ch_b = 12'h210;
  logic [3:0] bcd_b;
  logic [1:0] sel_b;
  logic [2:0] an_b;
  logic frame_b;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    int step;
    logic en;
    logic [5:0] mask;
    logic [23:0] ch;
    logic [2:0] sel;
    logic [3:0] bcd;
    logic [5:0] an;
    logic frame;
  } vec_t;
  vec_t tv[$];
  always #5 clk = ~clk;
  scan_mux_n #(.NCH(6), .W(4), .DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .ch(ch), .en(en), .blank_mask(blank_mask),
    .bcd(bcd), .sel(sel), .an(an), .frame(frame)
  );
  scan_mux_n #(.NCH(3), .W(4), .DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_nb), .ch(ch_b), .en(en_b), .blank_mask(3'b000),
    .bcd(bcd_b), .sel(sel_b), .an(an_b), .frame(frame_b)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    logic fseen;
    tv.push_back('{1, 1'b1, 6'h00, 24'h543210, 3'd0, 4'h0, 6'h3E, 1'b0});
    tv.push_back('{3, 1'b1, 6'h00, 24'h543210, 3'd0, 4'h0, 6'h3E, 1'b0});
    tv.push_back('{1, 1'b1, 6'h00, 24'h543210, 3'd1, 4'h1, 6'h3D, 1'b0});
    tv.push_back('{4, 1'b1, 6'h00, 24'h543210, 3'd2, 4'h2, 6'h3B, 1'b0});
    tv.push_back('{4, 1'b1, 6'h00, 24'h543210, 3'd3, 4'h3, 6'h37, 1'b0});
    tv.push_back('{4, 1'b1, 6'h00, 24'h543210, 3'd4, 4'h4, 6'h2F, 1'b0});
    tv.push_back('{4, 1'b1, 6'h00, 24'h543210, 3'd5, 4'h5, 6'h1F, 1'b0});
    tv.push_back('{3, 1'b1, 6'h00, 24'h543210, 3'd5, 4'h5, 6'h1F, 1'b1});
    tv.push_back('{1, 1'b1, 6'h00, 24'h543210, 3'd0, 4'h0, 6'h3E, 1'b0});
    tv.push_back('{8, 1'b1, 6'h04, 24'h543710, 3'd2, 4'hF, 6'h3F, 1'b0});
    tv.push_back('{1, 1'b1, 6'h00, 24'h543710, 3'd2, 4'h7, 6'h3B, 1'b0});
    tv.push_back('{1, 1'b1, 6'h00, 24'h543A10, 3'd2, 4'hA, 6'h3B, 1'b0});
    tv.push_back('{5, 1'b0, 6'h00, 24'h543A10, 3'd2, 4'hA, 6'h3B, 1'b0});
    tv.push_back('{1, 1'b1, 6'h00, 24'h543A10, 3'd2, 4'hA, 6'h3B, 1'b0});
    tv.push_back('{1, 1'b1, 6'h00, 24'h543A10, 3'd3, 4'h3, 6'h37, 1'b0});
    tv.push_back('{1, 1'b1, 6'h00, 24'h003000, 3'd3, 4'h3, 6'h37, 1'b0});
    tv.push_back('{4, 1'b1, 6'h00, 24'h003000, 3'd4, LZ ? 4'hF : 4'h0, LZ ? 6'h3F : 6'h2F, 1'b0});
    tv.push_back('{4, 1'b1, 6'h00, 24'h003000, 3'd5, LZ ? 4'hF : 4'h0, LZ ? 6'h3F : 6'h1F, 1'b0});
    tv.push_back('{2, 1'b1, 6'h00, 24'h003000, 3'd5, LZ ? 4'hF : 4'h0, LZ ? 6'h3F : 6'h1F, 1'b1});
    tv.push_back('{2, 1'b1, 6'h00, 24'h003000, 3'd0, 4'h0, 6'h3E, 1'b0});
    tv.push_back('{4, 1'b1, 6'h00, 24'h003000, 3'd1, 4'h0, 6'h3D, 1'b0});
    tv.push_back('{4, 1'b1, 6'h00, 24'h003000, 3'd2, 4'h0, 6'h3B, 1'b0});
    tick(2);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_an", 32'(an), 32'h3F);
    check("rst_bcd", 32'(bcd), 32'hF);
    check("rst_frame", 32'(frame), 32'd0);
    rst_n = 1'b1;
    foreach (tv[i]) begin
      en = tv[i].en;
      blank_mask = tv[i].mask;
      ch = tv[i].ch;
      tick(tv[i].step);
      check($sformatf("v%0d_sel", i), 32'(sel), 32'(tv[i].sel));
      check($sformatf("v%0d_bcd", i), 32'(bcd), 32'(tv[i].bcd));
      check($sformatf("v%0d_an", i), 32'(an), 32'(tv[i].an));
      check($sformatf("v%0d_frame", i), 32'(frame), 32'(tv[i].frame));
    end
    // land on sel=4 with the prescaler at 2, then reset asynchronously
    tick(8);
    check("mid_sel", 32'(sel), 32'd4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sel", 32'(sel), 32'd0);
    check("mid_rst_an", 32'(an), 32'h3F);
    check("mid_rst_bcd", 32'(bcd), 32'hF);
    check("mid_rst_frame", 32'(frame), 32'd0);
    tick(2);
    rst_n = 1'b1;
    fseen = 1'b0;
    for (int c = 1; c <= 23; c++) begin
      tick(1);
      fseen |= frame;
      if (c == 1) check("restart_an", 32'(an), 32'h3E);
      if (c == 4) check("restart_sel_hold", 32'(sel), 32'd0);
      if (c == 5) check("restart_sel1", 32'(sel), 32'd1);
    end
    check("restart_no_frame", 32'(fseen), 32'd0);
    rst_nb = 1'b1;
    tick(1);
    check("b1_sel", 32'(sel_b), 32'd0);
    check("b1_bcd", 32'(bcd_b), 32'd0);
    tick(1);
    check("b2_sel", 32'(sel_b), 32'd1);
    check("b2_an", 32'(an_b), 32'h5);
    tick(1);
    check("b3_sel", 32'(sel_b), 32'd2);
    check("b3_frame", 32'(frame_b), 32'd1);
    tick(1);
    check("b4_sel", 32'(sel_b), 32'd0);
    check("b4_frame", 32'(frame_b), 32'd0);
    en_b = 1'b0;
    fseen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      fseen |= frame_b;
      check($sformatf("bfrz%0d_sel", c), 32'(sel_b), 32'd1);
    end
    check("bfrz_no_frame", 32'(fseen), 32'd0);
    en_b = 1'b1;
    tick(1);
    check("b5_sel", 32'(sel_b), 32'd1);
    tick(1);
    check("b6_sel", 32'(sel_b), 32'd2);
    check("b6_frame", 32'(frame_b), 32'd1);
    tick(1);
    check("b7_sel", 32'(sel_b), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
